// File: rtl/prog_loader_stream.sv
// Streamed program loader: packs instruction words into imem lines, writes data words to dmem,
// and keeps the core in reset until the image is complete. Optional trailing checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader_stream #(
    parameter int FETCH_WIDTH = 4,
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [31:0]               in_data,
    output logic                      in_ready,
    input  logic                      reload,
    output logic                      imem_we,
    output logic [IMEM_ADDR_W-1:0]    imem_addr,
    output logic [FETCH_WIDTH*32-1:0] imem_wdata,
    output logic                      dmem_we,
    output logic [DMEM_ADDR_W-1:0]    dmem_addr,
    output logic [31:0]               dmem_wdata,
    output logic                      core_reset,
    output logic                      done,
    output logic                      err
);
    localparam int          LINE_W = FETCH_WIDTH * 32;
    localparam int          LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [32:0] I_CAP  = 33'(FETCH_WIDTH) << IMEM_ADDR_W;
    localparam logic [32:0] D_CAP  = 33'd1 << DMEM_ADDR_W;

    typedef enum logic [2:0] {
        HDR_I, LOAD_I, FLUSH, HDR_D, LOAD_D, CHK, DONE, ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t DATA_END = CHK;
    logic [31:0] sum;
`else
    localparam state_t DATA_END = DONE;
`endif

    state_t              state;
    logic [31:0]         n_i, n_d, cnt;
    logic [LANE_W-1:0]   lane;
    logic [IMEM_ADDR_W-1:0] line_idx;
    logic [LINE_W-1:0]   line_buf, line_next;
    logic                xfer, line_full, last_i, last_d;

    // Handshake: a word moves on any cycle where in_valid and in_ready are both high;
    // in_ready depends only on the registered state, never on in_valid.
    assign in_ready  = (state == HDR_I) || (state == LOAD_I) || (state == HDR_D) ||
                       (state == LOAD_D) || (state == CHK);
    assign xfer      = in_valid & in_ready;
    assign line_full = (lane == LANE_W'(FETCH_WIDTH - 1));
    assign last_i    = (cnt == n_i - 32'd1);
    assign last_d    = (cnt == n_d - 32'd1);

    // Lane 0 sits in the most significant word of the line.
    always_comb begin
        line_next = line_buf;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (lane == LANE_W'(k)) line_next[LINE_W-1-32*k -: 32] = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HDR_I;
            n_i        <= '0;
            n_d        <= '0;
            cnt        <= '0;
            lane       <= '0;
            line_idx   <= '0;
            line_buf   <= {FETCH_WIDTH{NOP}};
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            case (state)
                HDR_I: if (xfer) begin
                    n_i <= in_data;
                    cnt <= '0;
                    if ({1'b0, in_data} > I_CAP) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (in_data == 32'd0) begin
                        state <= HDR_D;
                    end else begin
                        state <= LOAD_I;
                    end
                end
                LOAD_I: if (xfer) begin
                    cnt <= cnt + 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum <= sum + in_data;
`endif
                    if (line_full) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= line_idx;
                        imem_wdata <= line_next;
                        line_idx   <= line_idx + IMEM_ADDR_W'(1);
                        line_buf   <= {FETCH_WIDTH{NOP}};
                        lane       <= '0;
                    end else begin
                        line_buf <= line_next;
                        lane     <= lane + LANE_W'(1);
                    end
                    if (last_i) state <= line_full ? HDR_D : FLUSH;
                end
                FLUSH: begin
                    // Unfilled lanes still hold the NOP fill loaded at line start.
                    imem_we    <= 1'b1;
                    imem_addr  <= line_idx;
                    imem_wdata <= line_buf;
                    line_idx   <= line_idx + IMEM_ADDR_W'(1);
                    line_buf   <= {FETCH_WIDTH{NOP}};
                    lane       <= '0;
                    state      <= HDR_D;
                end
                HDR_D: if (xfer) begin
                    n_d <= in_data;
                    cnt <= '0;
                    if ({1'b0, in_data} > D_CAP) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (in_data == 32'd0) begin
                        state <= DATA_END;
                        if (DATA_END == DONE) begin
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end
                    end else begin
                        state <= LOAD_D;
                    end
                end
                LOAD_D: if (xfer) begin
                    dmem_we    <= 1'b1;
                    dmem_addr  <= cnt[DMEM_ADDR_W-1:0];
                    dmem_wdata <= in_data;
                    cnt        <= cnt + 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum        <= sum + in_data;
`endif
                    if (last_d) begin
                        state <= DATA_END;
                        if (DATA_END == DONE) begin
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    if (in_data == sum) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        core_reset <= 1'b0;
                    end else begin
                        state <= ERR;
                        err   <= 1'b1;
                    end
                end
`endif
                DONE, ERR: if (reload) begin
                    state      <= HDR_I;
                    core_reset <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    n_i        <= '0;
                    n_d        <= '0;
                    cnt        <= '0;
                    lane       <= '0;
                    line_idx   <= '0;
                    line_buf   <= {FETCH_WIDTH{NOP}};
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum        <= '0;
`endif
                end
                default: state <= ERR;
            endcase
        end
    end
endmodule
